// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and helpers for the iterative RV32M multiply/divide unit
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_DATA_WIDTH = 32;
  localparam int MULDIV_CNT_WIDTH  = $clog2(MULDIV_DATA_WIDTH) + 1;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // REM/REMU select the remainder rather than the quotient
  function automatic logic op_is_rem(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM; MUL's low half is sign-agnostic
  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is signed for MULH, DIV and REM (MULHSU keeps it unsigned)
  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; optional MULDIV_FAST_MUL_EN single-cycle multiply
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      start_e_i,
  input  logic [2:0]                muldiv_op_e_i,
  input  logic [DATA_WIDTH-1:0]     op_a_e_i,
  input  logic [DATA_WIDTH-1:0]     op_b_e_i,
  input  logic [REGISTER_WIDTH-1:0] rd_e_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REGISTER_WIDTH-1:0] rd_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  muldiv_state_t             state_q, state_d;
  muldiv_op_t                op_in, op_q;
  logic [W-1:0]              opb_q;       // |divisor| or |multiplicand|
  logic [2*W-1:0]            acc_q;       // {remainder, quotient} or {product hi, multiplier/product lo}
  logic [CNT_W-1:0]          cnt_q;
  logic                      neg_q;       // product / quotient needs negation
  logic                      sa_q;        // dividend sign, gives the remainder sign
  logic [REGISTER_WIDTH-1:0] rd_q;
  logic                      done_q;

  logic                      accept;
  logic                      in_sa, in_sb;
  logic [W-1:0]              abs_a, abs_b;
  logic                      div_zero, div_ovf, special;
  logic [W-1:0]              special_res;
  logic                      fast_mul;
  logic [W-1:0]              fast_res;
  logic                      shortcut;
  logic [W-1:0]              shortcut_res;

  logic [W:0]                mul_sum;
  logic [2*W-1:0]            mul_next;
  logic [W:0]                div_shift;
  logic                      div_ge;
  logic [W-1:0]              div_diff;
  logic [2*W-1:0]            div_next;
  logic [2*W-1:0]            step_next;
  logic [2*W-1:0]            prod_fix;
  logic [W-1:0]              quo, rem;
  logic [W-1:0]              final_res;

  // Decode the incoming op: magnitudes, signs, and divides that finish without iterating
  always_comb begin
    op_in    = muldiv_op_t'(muldiv_op_e_i);
    accept   = (state_q == IDLE) & start_e_i & ~flush_i;
    in_sa    = op_a_signed(op_in) & op_a_e_i[W-1];
    in_sb    = op_b_signed(op_in) & op_b_e_i[W-1];
    abs_a    = in_sa ? (~op_a_e_i + 1'b1) : op_a_e_i;
    abs_b    = in_sb ? (~op_b_e_i + 1'b1) : op_b_e_i;
    div_zero = op_is_div(op_in) & (op_b_e_i == '0);
    div_ovf  = ((op_in == OP_DIV) | (op_in == OP_REM)) &
               (op_a_e_i == {1'b1, {(W-1){1'b0}}}) & (op_b_e_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_res = op_is_rem(op_in) ? op_a_e_i : '1;
    end else begin
      special_res = op_is_rem(op_in) ? '0 : {1'b1, {(W-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_a, fast_b, fast_prod;

  // Single-cycle product of the sign-extended operands; low 2W bits are exact
  always_comb begin
    fast_a    = {{W{op_a_signed(op_in) & op_a_e_i[W-1]}}, op_a_e_i};
    fast_b    = {{W{op_b_signed(op_in) & op_b_e_i[W-1]}}, op_b_e_i};
    fast_prod = fast_a * fast_b;
    fast_mul  = ~op_is_div(op_in);
    fast_res  = (op_in == OP_MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
  end
`else
  // Without the fast multiplier every multiply iterates
  always_comb begin
    fast_mul = 1'b0;
    fast_res = '0;
  end
`endif

  // Ops that complete straight from IDLE and the value they register
  always_comb begin
    shortcut     = special | fast_mul;
    shortcut_res = special ? special_res : fast_res;
  end

  // One radix-2 step: shift-add multiply or restoring divide, then final sign fix and select
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[W-1:0] - opb_q;
    div_next  = {(div_ge ? div_diff : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
    step_next = op_is_div(op_q) ? div_next : mul_next;
    prod_fix  = neg_q ? (~step_next + 1'b1) : step_next;
    quo       = neg_q ? (~step_next[W-1:0] + 1'b1) : step_next[W-1:0];
    rem       = sa_q ? (~step_next[2*W-1:W] + 1'b1) : step_next[2*W-1:W];
    case (op_q)
      OP_MUL:                      final_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:             final_res = quo;
      default:                     final_res = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush always wins and returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = shortcut ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: stall the pipeline while accepting or iterating; done is the registered DONE flag
  always_comb begin
    stall_o = ((state_q == IDLE) & start_e_i & ~flush_i) | (state_q == BUSY);
    done_o  = done_q;
  end

  // Datapath: operand capture, iteration, and result/rd registers
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= OP_MUL;
      rd_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      done_q   <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      done_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_e_i;
            opb_q <= abs_b;
            acc_q <= {{W{1'b0}}, abs_a};
            cnt_q <= CNT_W'(W);
            neg_q <= in_sa ^ in_sb;
            sa_q  <= in_sa;
            if (shortcut) begin
              result_o <= shortcut_res;
              rd_o     <= rd_e_i;
            end
          end
        end
        BUSY: begin
          if (!flush_i) begin
            acc_q <= step_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              result_o <= final_res;
              rd_o     <= rd_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
